// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register for a 5-stage RV64 pipeline.
// Single-cycle ALU plus a 1-bit-per-cycle iterative multiplier that stalls upstream.
module ex_mem_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [3:0]      id_alu_ctrl,
  input  logic            id_alu_src,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rd,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            flush,
  output logic            ex_stall,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_mem_to_reg,
  output logic            mem_zero
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SLL = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111,
    ALU_SLT  = 4'b1000, ALU_SLTU = 4'b1001, ALU_MUL = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_e;

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] mul_a_q, mul_a_d;
  logic [XLEN-1:0] mul_b_q, mul_b_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            mem_valid_q, mem_valid_d;
  logic [XLEN-1:0] mem_alu_result_q, mem_alu_result_d;
  logic [XLEN-1:0] mem_store_data_q, mem_store_data_d;
  logic [4:0]      mem_rd_q, mem_rd_d;
  logic            mem_reg_write_q, mem_reg_write_d;
  logic            mem_mem_read_q, mem_mem_read_d;
  logic            mem_mem_write_q, mem_mem_write_d;
  logic            mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic            mem_zero_q, mem_zero_d;

  logic [XLEN-1:0] op_b;
  logic [CW-1:0]   shamt;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] ex_result;
  logic            is_mul;
  logic            mul_start;

  assign op_b      = id_alu_src ? id_imm : id_rs2_data;
  assign shamt     = op_b[CW-1:0];
  assign is_mul    = (id_alu_ctrl == ALU_MUL);
  assign mul_start = (state_q == S_IDLE) && id_valid && is_mul && !flush;
  assign ex_stall  = mul_start || (state_q == S_BUSY);

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_result = '0;
    unique case (alu_op_e'(id_alu_ctrl))
      ALU_ADD:  alu_result = id_rs1_data + op_b;
      ALU_SUB:  alu_result = id_rs1_data - op_b;
      ALU_AND:  alu_result = id_rs1_data & op_b;
      ALU_OR:   alu_result = id_rs1_data | op_b;
      ALU_XOR:  alu_result = id_rs1_data ^ op_b;
      ALU_SLL:  alu_result = id_rs1_data << shamt;
      ALU_SRL:  alu_result = id_rs1_data >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(id_rs1_data) >>> shamt);
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(id_rs1_data) < $signed(op_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, id_rs1_data < op_b};
      default:  alu_result = '0;
    endcase
  end

  // The multiplier result replaces the ALU output only in the DONE cycle.
  assign ex_result = (state_q == S_DONE) ? acc_q : alu_result;

  always_comb begin
    state_d = state_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (mul_start) begin
          state_d = S_BUSY;
          mul_a_d = id_rs1_data;
          mul_b_d = op_b;
          acc_d   = '0;
          cnt_d   = '0;
        end
        S_BUSY: begin
          if (mul_b_q[0]) acc_d = acc_q + mul_a_q;
          mul_a_d = mul_a_q << 1;
          mul_b_d = mul_b_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_valid_d      = mem_valid_q;
    mem_alu_result_d = mem_alu_result_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_d         = mem_rd_q;
    mem_reg_write_d  = mem_reg_write_q;
    mem_mem_read_d   = mem_mem_read_q;
    mem_mem_write_d  = mem_mem_write_q;
    mem_mem_to_reg_d = mem_mem_to_reg_q;
    mem_zero_d       = mem_zero_q;
    if (flush || ex_stall || !id_valid) begin
      mem_valid_d     = 1'b0;
      mem_reg_write_d = 1'b0;
      mem_mem_read_d  = 1'b0;
      mem_mem_write_d = 1'b0;
      mem_mem_to_reg_d = 1'b0;
    end else begin
      mem_valid_d      = 1'b1;
      mem_alu_result_d = ex_result;
      mem_store_data_d = id_rs2_data;
      mem_rd_d         = id_rd;
      mem_reg_write_d  = id_reg_write && (id_rd != 5'd0);
      mem_mem_read_d   = id_mem_read;
      mem_mem_write_d  = id_mem_write;
      mem_mem_to_reg_d = id_mem_to_reg;
      mem_zero_d       = (ex_result == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mul_a_q <= '0;
      mul_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q      <= 1'b0;
      mem_alu_result_q <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_zero_q       <= 1'b0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_mem_to_reg_q <= mem_mem_to_reg_d;
      mem_zero_q       <= mem_zero_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_alu_result = mem_alu_result_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_rd         = mem_rd_q;
  assign mem_reg_write  = mem_reg_write_q;
  assign mem_mem_read   = mem_mem_read_q;
  assign mem_mem_write  = mem_mem_write_q;
  assign mem_mem_to_reg = mem_mem_to_reg_q;
  assign mem_zero       = mem_zero_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed vector table, hand-written
// multiply/flush/reset sequences, and random instructions against a reference model.
module tb_ex_mem_stage;

  localparam int XLEN = 64;
  localparam logic [3:0] OP_MUL = 4'b1010;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [3:0]      id_alu_ctrl;
  logic            id_alu_src;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rd;
  logic            id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic            flush;
  logic            ex_stall;
  logic            mem_valid;
  logic [XLEN-1:0] mem_alu_result, mem_store_data;
  logic [4:0]      mem_rd;
  logic            mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic            mem_zero;

  int checks   = 0;
  int failures = 0;

  ex_mem_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src(id_alu_src), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .flush(flush), .ex_stall(ex_stall),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_zero(mem_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            valid;
    logic [3:0]      ctrl;
    logic            src;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            rw, mr, mw, mtr;
    logic            flush;
  } instr_t;

  typedef struct packed {
    instr_t          in;
    logic            exp_valid;
    logic [XLEN-1:0] exp_result;
    logic            exp_zero;
    logic            exp_rw;
    logic            exp_mw;
  } vec_t;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(input logic [3:0] ctrl, input logic src, input logic [XLEN-1:0] rs1,
                                input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] imm,
                                input logic [4:0] rd, input logic rw);
    instr_t t;
    t = '0;
    t.valid = 1'b1; t.ctrl = ctrl; t.src = src; t.rs1 = rs1; t.rs2 = rs2;
    t.imm = imm; t.rd = rd; t.rw = rw;
    return t;
  endfunction

  // Architectural meaning of each opcode, written directly from the ISA rules.
  function automatic logic [XLEN-1:0] model_alu(input logic [3:0] ctrl, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    int sh;
    logic [2*XLEN-1:0] prod;
    sh = int'(b[5:0]);
    prod = a * b;
    case (ctrl)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return $unsigned($signed(a) >>> sh);
      4'd8:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9:  return (a < b) ? 64'd1 : 64'd0;
      4'd10: return prod[XLEN-1:0];
      default: return '0;
    endcase
  endfunction

  task automatic drive(input instr_t t);
    id_valid = t.valid; id_alu_ctrl = t.ctrl; id_alu_src = t.src;
    id_rs1_data = t.rs1; id_rs2_data = t.rs2; id_imm = t.imm; id_rd = t.rd;
    id_reg_write = t.rw; id_mem_read = t.mr; id_mem_write = t.mw;
    id_mem_to_reg = t.mtr; flush = t.flush;
  endtask

  task automatic idle();
    instr_t t;
    t = '0;
    drive(t);
  endtask

  // Presents one instruction as the upstream would (held while stalled) and
  // checks its EX/MEM image against the reference model.
  task automatic run_instr(input string tag, input instr_t t);
    logic            ev;
    logic [XLEN-1:0] b, er;
    int n;
    b  = t.src ? t.imm : t.rs2;
    er = model_alu(t.ctrl, t.rs1, b);
    ev = t.valid && !t.flush;
    drive(t);
    #1;
    if (ev && t.ctrl == OP_MUL) begin
      n = 0;
      while (ex_stall && n < 200) begin
        if (n > 0) check({tag, "_mul_bubble"}, {63'd0, mem_valid}, 64'd0);
        tick();
        n++;
      end
      check({tag, "_mul_stall_cycles"}, 64'(n), 64'(XLEN + 1));
      check({tag, "_done_bubble"}, {63'd0, mem_valid}, 64'd0);
    end else begin
      check({tag, "_no_stall"}, {63'd0, ex_stall}, 64'd0);
    end
    tick();
    flush = 1'b0;
    check({tag, "_valid"}, {63'd0, mem_valid}, {63'd0, ev});
    check({tag, "_reg_write"}, {63'd0, mem_reg_write}, {63'd0, ev && t.rw && t.rd != 5'd0});
    check({tag, "_mem_rd_en"}, {63'd0, mem_mem_read}, {63'd0, ev && t.mr});
    check({tag, "_mem_wr_en"}, {63'd0, mem_mem_write}, {63'd0, ev && t.mw});
    check({tag, "_mem_to_reg"}, {63'd0, mem_mem_to_reg}, {63'd0, ev && t.mtr});
    if (ev) begin
      check({tag, "_result"}, mem_alu_result, er);
      check({tag, "_zero"}, {63'd0, mem_zero}, {63'd0, er == '0});
      check({tag, "_store_data"}, mem_store_data, t.rs2);
      check({tag, "_rd"}, {59'd0, mem_rd}, {59'd0, t.rd});
    end
  endtask

  vec_t   vecs [14];
  instr_t t;

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_result", mem_alu_result, 64'd0);
    check("rst_store", mem_store_data, 64'd0);
    check("rst_ctrl", {57'd0, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_zero}, 64'd0);
    check("rst_stall", {63'd0, ex_stall}, 64'd0);

    // Directed vectors with hand-computed expectations.
    vecs[0]  = '{mk(4'd0, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 5'd7, 1'b1), 1'b1, 64'd2, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{mk(4'd1, 1'b0, 64'd9, 64'd9, 64'd0, 5'd3, 1'b1), 1'b1, 64'd0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{mk(4'd7, 1'b0, 64'h8000_0000_0000_0000, 64'h41, 64'd0, 5'd4, 1'b1), 1'b1, 64'hC000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{mk(4'd8, 1'b0, '1, 64'd1, 64'd0, 5'd5, 1'b1), 1'b1, 64'd1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{mk(4'd9, 1'b0, '1, 64'd1, 64'd0, 5'd5, 1'b1), 1'b1, 64'd0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{mk(4'd0, 1'b0, 64'd1, 64'd1, 64'd0, 5'd0, 1'b1), 1'b1, 64'd2, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{mk(4'd2, 1'b0, 64'hF0F0, 64'hFF00, 64'd0, 5'd8, 1'b0), 1'b1, 64'hF000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{mk(4'd3, 1'b1, 64'hF0F0, 64'd0, 64'h0F0F, 5'd9, 1'b1), 1'b1, 64'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{mk(4'd4, 1'b0, 64'h1234, 64'h1234, 64'd0, 5'd10, 1'b1), 1'b1, 64'd0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{mk(4'd5, 1'b1, 64'd1, 64'd0, 64'd63, 5'd11, 1'b1), 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{mk(4'd6, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 64'd63, 5'd12, 1'b1), 1'b1, 64'd1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{mk(4'd15, 1'b0, 64'd7, 64'd8, 64'd0, 5'd13, 1'b1), 1'b1, 64'd0, 1'b1, 1'b1, 1'b0};
    t = mk(4'd0, 1'b1, 64'd100, 64'hDEAD, 64'd8, 5'd0, 1'b0);
    t.mw = 1'b1; t.flush = 1'b1;
    vecs[12] = '{t, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0};
    t = mk(4'd0, 1'b0, 64'd1, 64'd2, 64'd0, 5'd14, 1'b1);
    t.valid = 1'b0;
    vecs[13] = '{t, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].in);
      #1;
      check($sformatf("vec%0d_stall", i), {63'd0, ex_stall}, 64'd0);
      tick();
      flush = 1'b0;
      check($sformatf("vec%0d_valid", i), {63'd0, mem_valid}, {63'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_rw", i), {63'd0, mem_reg_write}, {63'd0, vecs[i].exp_rw});
      check($sformatf("vec%0d_mw", i), {63'd0, mem_mem_write}, {63'd0, vecs[i].exp_mw});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_result", i), mem_alu_result, vecs[i].exp_result);
        check($sformatf("vec%0d_zero", i), {63'd0, mem_zero}, {63'd0, vecs[i].exp_zero});
        check($sformatf("vec%0d_rd", i), {59'd0, mem_rd}, {59'd0, vecs[i].in.rd});
      end
    end

    // MUL -1 x 3 followed directly by an ADD.
    run_instr("mul_neg", mk(OP_MUL, 1'b0, '1, 64'd3, 64'd0, 5'd6, 1'b1));
    check("mul_neg_product", mem_alu_result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_instr("add_after_mul", mk(4'd0, 1'b1, 64'd40, 64'd0, 64'd2, 5'd15, 1'b1));
    check("add_after_mul_value", mem_alu_result, 64'd42);

    // MUL 12 x 13 flushed in BUSY cycle 20, then a clean MUL 2 x 3.
    drive(mk(OP_MUL, 1'b0, 64'd12, 64'd13, 64'd0, 5'd2, 1'b1));
    #1;
    check("mflush_stall_c0", {63'd0, ex_stall}, 64'd1);
    repeat (20) tick();
    check("mflush_stall_c20", {63'd0, ex_stall}, 64'd1);
    flush = 1'b1;
    tick();
    idle();
    #1;
    check("mflush_valid_c21", {63'd0, mem_valid}, 64'd0);
    check("mflush_stall_c21", {63'd0, ex_stall}, 64'd0);
    for (int i = 0; i < 70; i++) begin
      tick();
      if (mem_valid) check("mflush_no_product", {63'd0, mem_valid}, 64'd0);
    end
    check("mflush_quiet", {63'd0, mem_valid}, 64'd0);
    run_instr("mul_restart", mk(OP_MUL, 1'b1, 64'd2, 64'd0, 64'd3, 5'd9, 1'b1));
    check("mul_restart_value", mem_alu_result, 64'd6);

    // Reset in the middle of a multiply.
    drive(mk(OP_MUL, 1'b0, 64'd5, 64'd7, 64'd0, 5'd3, 1'b1));
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("mrst_valid", {63'd0, mem_valid}, 64'd0);
    check("mrst_result", mem_alu_result, 64'd0);
    check("mrst_stall", {63'd0, ex_stall}, 64'd0);
    run_instr("mrst_next_mul", mk(OP_MUL, 1'b0, 64'd11, 64'd11, 64'd0, 5'd3, 1'b1));

    // Random instructions against the reference model.
    for (int i = 0; i < 250; i++) begin
      t = '0;
      t.valid = ($urandom_range(0, 9) != 0);
      t.ctrl  = 4'($urandom_range(0, 15));
      if (t.ctrl == OP_MUL && $urandom_range(0, 2) != 0) t.ctrl = 4'd0;
      t.src   = 1'($urandom_range(0, 1));
      t.rs1   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      t.rs2   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      t.imm   = ($urandom_range(0, 1) == 0) ? 64'($signed(12'($urandom))) : {$urandom, $urandom};
      t.rd    = 5'($urandom_range(0, 31));
      t.rw    = 1'($urandom_range(0, 1));
      t.mr    = 1'($urandom_range(0, 1));
      t.mw    = 1'($urandom_range(0, 1));
      t.mtr   = 1'($urandom_range(0, 1));
      t.flush = ($urandom_range(0, 15) == 0);
      run_instr($sformatf("rnd%0d", i), t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register of the 5-stage RV64 pipeline. It consumes the ID/EX register outputs, selects operand B (register or immediate) and computes the ALU result. MUL runs on an iterative 1-bit-per-cycle multiplier that stalls upstream. It registers the result, store data, destination and control bits for the MEM stage, and supports flush and bubble insertion.

## Interface
- XLEN, 64, datapath width; the multiplier iterates XLEN cycles.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID/EX holds a real instruction.
- id_alu_ctrl  in  4  ALU operation codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
  - 1010 MUL (low XLEN bits of the product).
  - 1011-1111 give result 0.
- id_alu_src  in  1  0 = operand B is rs2, 1 = operand B is immediate.
- id_rs1_data, id_rs2_data, id_imm  in  XLEN each  operands.
- id_rd  in  5  destination register.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits.
- flush  in  1  squash the instruction in EX and abort any multiply.
- ex_stall  out  1  upstream must hold PC, IF/ID and ID/EX this cycle.
- mem_valid  out  1  EX/MEM holds a real instruction.
- mem_alu_result  out  XLEN  registered result.
- mem_store_data  out  XLEN  registered rs2 data.
- mem_rd  out  5  registered destination register.
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1 each  registered control bits, each gated by valid.
- mem_zero  out  1  registered (result == 0).

## Operation
- Operand A = rs1. Operand B = id_alu_src ? imm : rs2.
- Shifts use B[5:0]. SRA is arithmetic.
- SLT compares signed; SLTU compares unsigned; each returns 0 or 1.
- ADD, SUB and MUL wrap modulo 2^XLEN.
- mem_reg_write is forced to 0 when id_rd == 0.
- Multiplier FSM has three states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when id_valid & MUL & !flush. Latch A and B, clear the accumulator and the counter.
  - BUSY: each cycle, if B[0] then acc += A. Then A <<= 1, B >>= 1, cnt++. After the iteration with cnt == XLEN-1, go to DONE.
  - DONE -> IDLE unconditionally. The EX/MEM register captures acc together with the held ID/EX control bits.
- ex_stall = (IDLE & id_valid & MUL & !flush) | BUSY. It is combinational and is low in DONE.
- EX/MEM update priority: rst > flush > (ex_stall inserts a bubble) > load.
  - A bubble sets mem_valid and all write/read enables to 0; data fields are don't-care.
  - Non-MUL instructions and DONE cycles load normally.
  - id_valid = 0 loads a bubble.
- flush in any FSM state returns the FSM to IDLE and loads a bubble; the partial product is discarded.
- A MUL flushed in its IDLE presentation cycle never enters BUSY.

## Timing
- Reset: all outputs 0, FSM in IDLE, ex_stall = 0 (mem_valid = 0 as well).
- Non-MUL latency is 1: presented in cycle N, visible on mem_* in cycle N+1. Back-to-back issue every cycle, no stall.
- MUL latency:
  - Presented in cycle 0; ex_stall high in cycles 0..XLEN (XLEN+1 cycles).
  - BUSY covers cycles 1..XLEN.
  - DONE is cycle XLEN+1, with ex_stall low.
  - Product visible on mem_* in cycle XLEN+2.
- mem_valid = 0 in cycles 1..XLEN+1 of a MUL.
- ID/EX advances at the end of the DONE cycle, so the next instruction executes in cycle XLEN+2.
- Flush asserted in cycle k: mem_valid = 0 in cycle k+1, FSM is IDLE in cycle k+1, and ex_stall is low in cycle k+1 unless a new MUL is presented.
- rst mid-multiply behaves identically to flush and also zeroes all outputs.

## Test plan
- After reset: all outputs 0 in the first cycle after rst falls.
- ADD rs1=5, imm=-3, alu_src=1, rd=7, reg_write=1 -> next cycle mem_alu_result=2, mem_rd=7, mem_reg_write=1, mem_zero=0.
- SUB 9-9 -> result 0, mem_zero=1.
- SRA 0x8000_0000_0000_0000 by rs2=0x41 (shift 1) -> 0xC000_0000_0000_0000.
- SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
- rd=0 with reg_write=1 -> mem_reg_write=0.
- MUL 0xFFFF_FFFF_FFFF_FFFF × 3 -> ex_stall high for 65 cycles; then 0xFFFF_FFFF_FFFF_FFFD with mem_valid=1 in cycle 66; an ADD queued behind it completes in cycle 67.
- MUL 12×13 with flush in BUSY cycle 20 -> mem_valid=0 in cycle 21, ex_stall low in cycle 21, no product ever emitted. A following MUL 2×3 restarts cleanly and yields 6.
- Store, rs2=0xDEAD, mem_write=1, with flush in the same cycle -> mem_mem_write=0 and mem_valid=0 in the next cycle.
